// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit operands summed DIGIT bits per clock, LSB digit first,
// through one registered carry. Optional subtract port enabled by SERIAL_ADDER_SUB_EN.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             c_out,
   output logic             overflow
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   if ((WIDTH < 2) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_param_check
      $error("serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, next_state;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             accept, step_en, last;
   logic             sub_eff;
   logic [WIDTH-1:0] b_cap;
   logic             c_cap;
   logic [DIGIT-1:0] dsum;
   logic             dcarry, msb_cin;
   logic [WIDTH+DIGIT-1:0] res_cat;
   logic [WIDTH-1:0] res_next;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_eff = sub;
`else
   assign sub_eff = 1'b0;
`endif

   // Subtraction is A + ~B + 1: invert B and force the carry on capture.
   assign b_cap = b_in ^ {WIDTH{sub_eff}};
   assign c_cap = sub_eff | c_in;

   assign {dcarry, dsum} = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                         + (DIGIT+1)'(carry);
   // Carry into the digit's top bit, recovered from its sum and operand bits.
   assign msb_cin  = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ dsum[DIGIT-1];
   assign res_cat  = {dsum, res_sr};
   assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned and infers a latch.
      next_state = state;
      busy       = 1'b0;
      accept     = 1'b0;
      step_en    = 1'b0;
      last       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            busy    = 1'b1;
            step_en = 1'b1;
            if (cnt == LAST) begin
               last       = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         done     <= 1'b0;
         sum_out  <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= last;
         if (accept) begin
            a_sr  <= a_in;
            b_sr  <= b_cap;
            carry <= c_cap;
            cnt   <= '0;
         end else if (step_en) begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            res_sr <= res_next;
            carry  <= dcarry;
            cnt    <= cnt + 1'b1;
            if (last) begin
               sum_out  <= res_next;
               c_out    <= dcarry;
               overflow <= msb_cin ^ dcarry;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit/1-bit-digit and a 16-bit/4-bit-digit instance
// checked against an arithmetic reference model with directed and random operations.
module tb_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start8 = 1'b0, start16 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        c8 = 1'b0, c16 = 1'b0;
   logic        s8 = 1'b0, s16 = 1'b0;
   logic        busy8, done8, cout8, ovf8;
   logic        busy16, done16, cout16, ovf16;
   logic [7:0]  sum8;
   logic [15:0] sum16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .c_in(c8),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(s8),
`endif
      .busy(busy8), .done(done8), .sum_out(sum8), .c_out(cout8), .overflow(ovf8)
   );

   serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .a_in(a16), .b_in(b16), .c_in(c16),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(s16),
`endif
      .busy(busy16), .done(done16), .sum_out(sum16), .c_out(cout16), .overflow(ovf16)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {overflow, c_out, sum} from plain integer arithmetic on w-bit operands.
   function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic ci, input logic sub);
      int unsigned mask, bb, cc, tot, s, co, sa, sb, ss;
      logic ov;
      mask = (32'd1 << w) - 1;
      bb   = sub ? (~{16'h0, b}) & mask : {16'h0, b} & mask;
      cc   = sub ? 1 : {31'd0, ci};
      tot  = {16'h0, a} + bb + cc;
      s    = tot & mask;
      co   = (tot >> w) & 1;
      sa   = ({16'h0, a} >> (w - 1)) & 1;
      sb   = (bb >> (w - 1)) & 1;
      ss   = (s >> (w - 1)) & 1;
      ov   = (sa == sb) && (ss != sa);
      return {ov, co[0], s[15:0]};
   endfunction

   function automatic logic get_done(input bit sel);
      return sel ? done16 : done8;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input bit sel, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sub);
      if (!sel) begin
         a8 = a[7:0]; b8 = b[7:0]; c8 = ci; s8 = sub; start8 = 1'b1;
      end else begin
         a16 = a; b16 = b; c16 = ci; s16 = sub; start16 = 1'b1;
      end
      step();
      start8  = 1'b0;
      start16 = 1'b0;
   endtask

   task automatic finish_op(input bit sel, input string tag, input int elapsed,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic sub);
      int n;
      bit seen;
      logic [17:0] exp;
      n    = elapsed;
      seen = 1'b0;
      exp  = model(sel ? 16 : 8, a, b, ci, sub);
      while (!seen && n < 40) begin
         step();
         n++;
         seen = get_done(sel);
      end
      check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
      if (seen) begin
         check({tag, "_latency"}, n, sel ? 32'd4 : 32'd8);
         check({tag, "_sum"}, sel ? {16'h0, sum16} : {24'h0, sum8}, {16'h0, exp[15:0]});
         check({tag, "_cout"}, {31'd0, sel ? cout16 : cout8}, {31'd0, exp[16]});
         check({tag, "_ovf"}, {31'd0, sel ? ovf16 : ovf8}, {31'd0, exp[17]});
         check({tag, "_busy_low"}, {31'd0, sel ? busy16 : busy8}, 32'd0);
      end
   endtask

   initial begin
      int pulses;
      logic [15:0] ra, rb;
      logic rc, rs;

      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("reset_busy", {31'd0, busy8}, 32'd0);
      check("reset_done", {31'd0, done8}, 32'd0);
      check("reset_sum", {24'd0, sum8}, 32'd0);
      check("reset_sum16", {16'd0, sum16}, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Carry ripples across all eight columns.
      launch(0, 16'hFF, 16'h01, 1'b0, 1'b0);
      check("ripple_busy", {31'd0, busy8}, 32'd1);
      finish_op(0, "ripple", 0, 16'hFF, 16'h01, 1'b0, 1'b0);
      step();
      check("ripple_done_single", {31'd0, done8}, 32'd0);

      launch(0, 16'hA5, 16'h5A, 1'b1, 1'b0);
      finish_op(0, "full_cin", 0, 16'hA5, 16'h5A, 1'b1, 1'b0);
      launch(0, 16'h7F, 16'h01, 1'b0, 1'b0);
      finish_op(0, "signed_ovf", 0, 16'h7F, 16'h01, 1'b0, 1'b0);

      // Reset mid-run: abandon the operation, no done pulse afterwards.
      launch(0, 16'h33, 16'h44, 1'b0, 1'b0);
      step();
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy8}, 32'd0);
      check("midrst_done", {31'd0, done8}, 32'd0);
      check("midrst_sum", {24'd0, sum8}, 32'd0);
      check("midrst_cout", {31'd0, cout8}, 32'd0);
      check("midrst_ovf", {31'd0, ovf8}, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done8) pulses++;
      end
      check("midrst_no_done", pulses, 32'd0);
      launch(0, 16'h01, 16'h01, 1'b0, 1'b0);
      finish_op(0, "after_rst", 0, 16'h01, 16'h01, 1'b0, 1'b0);

      // Start while busy is ignored; a start in the done cycle is accepted.
      launch(0, 16'h10, 16'h20, 1'b0, 1'b0);
      step();
      step();
      a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
      step();
      start8 = 1'b0;
      check("busy_start_busy", {31'd0, busy8}, 32'd1);
      finish_op(0, "busy_start", 3, 16'h10, 16'h20, 1'b0, 1'b0);
      launch(0, 16'h3C, 16'h0F, 1'b0, 1'b0);
      finish_op(0, "b2b", 0, 16'h3C, 16'h0F, 1'b0, 1'b0);
      step();
      check("b2b_done_single", {31'd0, done8}, 32'd0);

      launch(1, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
      finish_op(1, "wide", 0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
      launch(0, 16'h05, 16'h07, 1'b0, 1'b1);
      finish_op(0, "sub_borrow", 0, 16'h05, 16'h07, 1'b0, 1'b1);
      launch(0, 16'h80, 16'h01, 1'b1, 1'b1);
      finish_op(0, "sub_ovf", 0, 16'h80, 16'h01, 1'b1, 1'b1);
`endif

      for (int i = 0; i < 16; i++) begin
         ra = 16'($urandom_range(0, 255));
         rb = 16'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         launch(0, ra, rb, rc, rs);
         finish_op(0, "rand8", 0, ra, rb, rc, rs);
      end

      for (int i = 0; i < 10; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 16'($urandom_range(0, 65535));
         rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         launch(1, ra, rb, rc, rs);
         finish_op(1, "rand16", 0, ra, rb, rc, rs);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle digit-serial adder; the sequential successor of the team's single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB digit first, through one registered carry.
- Start/busy/done handshake.
- Used where area matters more than latency: datapath accumulators and checksum units.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2.
- DIGIT, 1, bits added per clock; must divide WIDTH exactly (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  operand A; captured on accepted start
- b_in  input  WIDTH  operand B; captured on accepted start
- c_in  input  1  carry-in; captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- sum_out  output  WIDTH  registered result; holds until next completion
- c_out  output  1  registered unsigned carry-out
- overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset: asynchronous assertion (rst_n=0) forces the following, with no clock needed:
  - state = IDLE
  - busy, done, c_out, overflow = 0
  - sum_out = 0
  - internal shift registers, carry and digit counter = 0
- Reset mid-operation: the operation is abandoned; no done pulse is generated.
- FSM states: IDLE, RUN.
- IDLE, start=1 at an edge:
  - latch a_in, b_in and c_in into the operand shift registers and the carry register
  - clear the digit counter
  - go to RUN; busy=1 from the next cycle
- IDLE, start=0: stay in IDLE. done=0 except for the completion pulse described below.
- RUN, each edge:
  - add the low DIGIT bits of A and B plus the carry register
  - shift the DIGIT-bit digit sum into the result register from the MSB side
  - shift A and B right by DIGIT
  - update the carry register and increment the counter
- RUN, on the final digit (counter = WIDTH/DIGIT-1):
  - load sum_out, c_out and overflow at that edge
  - done=1 for exactly the following cycle
  - busy=0; return to IDLE
- Latency: done is high in the cycle beginning WIDTH/DIGIT edges after the edge that sampled start.
- Throughput: a new start may be sampled in the same cycle done is high, giving back-to-back operations with one IDLE cycle between RUN phases.
- start while busy is ignored; operands are not re-captured and the result is unaffected.
- Arithmetic:
  - {c_out, sum_out} = a_in + b_in + c_in, computed modulo 2^(WIDTH+1)
  - overflow is evaluated on the MSB column only

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - adds input port sub (1 bit), captured with the operands on accepted start
  - sub=1 inverts b_in on capture and forces the captured carry to 1, ignoring c_in; the result is a_in - b_in
  - with sub=1, c_out=1 means no borrow, and overflow is signed subtraction overflow
  - sub=0 behaves exactly as plain addition
- Undefined: no sub port; add-only behaviour as above.

Test Plan:
- Reset mid-run: WIDTH=8, start with 8'h33+8'h44, drop rst_n after 3 cycles -> busy=0, done never pulses, sum_out=8'h00, c_out=0. After release, a new 8'h01+8'h01 gives sum_out=8'h02.
- Carry ripple: WIDTH=8, DIGIT=1, 8'hFF+8'h01, c_in=0 -> done exactly 8 cycles after start edge; sum_out=8'h00, c_out=1, overflow=0.
- Full add with carry-in: 8'hA5+8'h5A, c_in=1 -> sum_out=8'h00, c_out=1. Then 8'h7F+8'h01, c_in=0 -> sum_out=8'h80, overflow=1, c_out=0.
- Start while busy: start 8'h10+8'h20, re-pulse start with 8'hFF+8'hFF at cycle 3 -> single done; sum_out=8'h30, c_out=0. A start asserted in the done cycle is accepted and completes 8 cycles later.
- Wide digits: WIDTH=16, DIGIT=4, 16'h1234+16'h0FFF -> done 4 cycles after start edge; sum_out=16'h2233, c_out=0.
- SERIAL_ADDER_SUB_EN defined, sub=1:
  - 8'h05-8'h07 -> sum_out=8'hFE, c_out=0, overflow=0
  - 8'h80-8'h01 -> sum_out=8'h7F, c_out=1, overflow=1
